issue_scoreboard: RTL and testbench

ISSUE_SCOREBOARD -- requirements
Module: issue_scoreboard

---
 rtl/issue_scoreboard_pkg.sv | 21 ++
 rtl/issue_scoreboard_sat_counter.sv | 27 ++
 rtl/issue_scoreboard.sv | 109 ++++++++++
 tb/tb_issue_scoreboard.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/issue_scoreboard_pkg.sv
// Shared processor definitions for the issue scoreboard, forwarding and hazard logic.
package issue_scoreboard_pkg;

  localparam int unsigned ARCH_NREG = 32;
  localparam int unsigned REG_IDX_W = 5;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_DRAIN = 2'd2
  } sb_state_e;

  // One-hot mask for a register index; index 0 never produces a bit.
  function automatic logic [ARCH_NREG-1:0] reg_mask(input logic [REG_IDX_W-1:0] idx);
    logic [ARCH_NREG-1:0] m;
    m = '0;
    if (idx != '0) m[idx] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/issue_scoreboard_sat_counter.sv
// Saturating up-counter used for the stall-cycle statistic.
module issue_scoreboard_sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Hold at all-ones instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) cnt_d = cnt_q + WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/issue_scoreboard.sv
// In-order issue scoreboard: tracks in-flight register writes, stalls RAW hazards
// and drains the pipeline after a flush.
module issue_scoreboard
  import issue_scoreboard_pkg::*;
#(
  parameter int unsigned NREG  = ARCH_NREG,
  parameter int unsigned CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic [REG_IDX_W-1:0] id_rd,
  input  logic                 id_regwrite,
  input  logic                 wb_valid,
  input  logic                 wb_regwrite,
  input  logic [REG_IDX_W-1:0] wb_rd,
  input  logic                 flush,
  output logic                 issue,
  output logic                 stall,
  output logic [NREG-1:0]      sb_pending,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic                 sb_err
);

  sb_state_e       state_q, state_d;
  logic [NREG-1:0] pending_q, pending_d;
  logic            err_q, err_d;

  logic            clr;
  logic [NREG-1:0] clr_mask;
  logic [NREG-1:0] set_mask;
  logic [NREG-1:0] eff;
  logic            rs1_busy;
  logic            rs2_busy;
  logic            hazard;

  // Write-back writes through the register file, so a retiring register is not a hazard.
  assign clr      = wb_valid & wb_regwrite & (wb_rd != '0);
  assign clr_mask = clr ? NREG'(reg_mask(wb_rd)) : '0;
  assign eff      = pending_q & ~clr_mask;
  assign rs1_busy = (id_rs1 != '0) & eff[id_rs1];
  assign rs2_busy = (id_rs2 != '0) & eff[id_rs2];
  assign hazard   = id_valid & (rs1_busy | rs2_busy);

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  // Flush wins over everything; DRAIN exits once the scoreboard empties.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_DRAIN;
    end else begin
      unique case (state_q)
        ST_RUN:   if (hazard)             state_d = ST_STALL;
        ST_STALL: if (!hazard)            state_d = ST_RUN;
        ST_DRAIN: if (pending_d == '0)    state_d = ST_RUN;
        default:                          state_d = ST_RUN;
      endcase
    end
  end

  always_comb begin
    issue = 1'b0;
    stall = 1'b0;
    if (!rst && !flush) begin
      if (state_q == ST_DRAIN) begin
        stall = 1'b1;
      end else begin
        issue = id_valid & ~hazard;
        stall = hazard;
      end
    end
  end

  // Set after clear so a same-cycle set of the same index wins.
  always_comb begin
    set_mask  = (issue & id_regwrite) ? NREG'(reg_mask(id_rd)) : '0;
    pending_d = (pending_q & ~clr_mask) | set_mask;
    err_d     = err_q | (clr & ~pending_q[wb_rd]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
      err_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      err_q     <= err_d;
    end
  end

  issue_scoreboard_sat_counter #(
    .WIDTH(CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (stall),
    .cnt_o (stall_cnt)
  );

  assign sb_pending = pending_q;
  assign sb_err     = err_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Bench for issue_scoreboard: per-cycle reference model plus directed scenarios.
module tb_issue_scoreboard;

  localparam int unsigned NR   = 32;
  localparam int unsigned CW   = 4;
  localparam int          SATV = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid;
  logic [4:0]    id_rs1, id_rs2, id_rd;
  logic          id_regwrite;
  logic          wb_valid, wb_regwrite;
  logic [4:0]    wb_rd;
  logic          flush;
  logic          issue, stall;
  logic [NR-1:0] sb_pending;
  logic [CW-1:0] stall_cnt;
  logic          sb_err;

  always #5 clk = ~clk;

  issue_scoreboard #(.NREG(NR), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .wb_valid(wb_valid),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .flush(flush), .issue(issue),
    .stall(stall), .sb_pending(sb_pending), .stall_cnt(stall_cnt), .sb_err(sb_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: set of in-flight registers, a draining flag, error and stall count.
  bit m_pend [NR];
  bit m_drain;
  bit m_err;
  int m_cnt;
  bit m_ok = 1'b0;

  function automatic bit m_clr();
    return wb_valid && wb_regwrite && (wb_rd != 0);
  endfunction

  function automatic bit m_busy(input int r);
    if (r == 0) return 1'b0;
    if (m_clr() && (int'(wb_rd) == r)) return 1'b0;
    return m_pend[r];
  endfunction

  function automatic bit m_haz();
    return id_valid && (m_busy(int'(id_rs1)) || m_busy(int'(id_rs2)));
  endfunction

  function automatic bit m_issue();
    if (rst || flush || m_drain) return 1'b0;
    return id_valid && !m_haz();
  endfunction

  function automatic bit m_stall();
    if (rst || flush) return 1'b0;
    if (m_drain) return 1'b1;
    return m_haz();
  endfunction

  function automatic logic [NR-1:0] m_vec();
    logic [NR-1:0] v;
    for (int i = 0; i < NR; i++) v[i] = m_pend[i];
    return v;
  endfunction

  function automatic bit m_any();
    for (int i = 0; i < NR; i++) if (m_pend[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
    end
  endtask

  bit ei, es;
  always @(posedge clk) begin
    ei = m_issue();
    es = m_stall();
    if (rst) begin
      foreach (m_pend[i]) m_pend[i] = 1'b0;
      m_drain = 1'b0;
      m_err   = 1'b0;
      m_cnt   = 0;
      m_ok    = 1'b1;
    end else begin
      if (es && m_cnt < SATV) m_cnt++;
      if (m_clr()) begin
        if (!m_pend[wb_rd]) m_err = 1'b1;
        m_pend[wb_rd] = 1'b0;
      end
      if (ei && id_regwrite && id_rd != 0) m_pend[id_rd] = 1'b1;
      if (flush)        m_drain = 1'b1;
      else if (m_drain) m_drain = m_any();
    end
  end

  // Per-cycle compare, mid-cycle so inputs and outputs are settled.
  always @(negedge clk) begin
    if (m_ok) begin
      check("model_issue",   64'(issue),      64'(m_issue()));
      check("model_stall",   64'(stall),      64'(m_stall()));
      check("model_pending", 64'(sb_pending), 64'(m_vec()));
      check("model_cnt",     64'(stall_cnt),  64'(m_cnt));
      check("model_err",     64'(sb_err),     64'(m_err));
    end
  end

  task automatic drive(input bit v, input int s1, input int s2, input int d, input bit w,
                       input bit wv, input int wd, input bit fl, input bit r);
    id_valid    = v;
    id_rs1      = 5'(s1);
    id_rs2      = 5'(s2);
    id_rd       = 5'(d);
    id_regwrite = w;
    wb_valid    = wv;
    wb_regwrite = wv;
    wb_rd       = 5'(wd);
    flush       = fl;
    rst         = r;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1, 3, 4, 5, 1, 1, 6, 1, 1);
    check("rst_issue", 64'(issue), 64'd0);
    check("rst_stall", 64'(stall), 64'd0);
    tick();
    tick();
    check("rst_pending", 64'(sb_pending), 64'd0);
    check("rst_cnt",     64'(stall_cnt),  64'd0);
    check("rst_err",     64'(sb_err),     64'd0);

    // RAW stall on rd=5 until its write-back
    drive(1, 1, 2, 5, 1, 0, 0, 0, 0);
    check("raw_issue0", 64'(issue), 64'd1);
    tick();
    check("raw_pend5", 64'(sb_pending), 64'h20);
    drive(1, 5, 0, 6, 1, 0, 0, 0, 0);
    check("raw_stall", 64'(stall), 64'd1);
    check("raw_noissue", 64'(issue), 64'd0);
    tick();
    tick();
    drive(1, 5, 0, 6, 1, 1, 5, 0, 0);
    check("raw_wb_issue", 64'(issue), 64'd1);
    check("raw_wb_stall", 64'(stall), 64'd0);
    tick();
    check("raw_pend6", 64'(sb_pending), 64'h40);
    check("raw_cnt", 64'(stall_cnt), 64'd2);
    drive(0, 0, 0, 0, 0, 1, 6, 0, 0);
    tick();
    check("raw_empty", 64'(sb_pending), 64'd0);

    // x0 never tracked; write-back to x0 ignored
    drive(1, 0, 0, 0, 1, 1, 0, 0, 0);
    check("x0_issue", 64'(issue), 64'd1);
    tick();
    check("x0_pending", 64'(sb_pending), 64'd0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    check("x0_nostall", 64'(stall), 64'd0);
    tick();
    check("x0_noerr", 64'(sb_err), 64'd0);

    // Same-cycle set and clear of rd=7
    drive(1, 0, 0, 7, 1, 0, 0, 0, 0);
    tick();
    check("sc_pend7", 64'(sb_pending), 64'h80);
    drive(1, 0, 0, 7, 1, 1, 7, 0, 0);
    check("sc_issue", 64'(issue), 64'd1);
    tick();
    check("sc_setwins", 64'(sb_pending), 64'h80);
    drive(0, 0, 0, 0, 0, 1, 7, 0, 0);
    tick();
    check("sc_cleared", 64'(sb_pending), 64'd0);
    check("sc_noerr", 64'(sb_err), 64'd0);

    // Flush with rd=3, rd=4 in flight, then drain
    drive(1, 0, 0, 3, 1, 0, 0, 0, 0);
    tick();
    drive(1, 0, 0, 4, 1, 0, 0, 0, 0);
    tick();
    check("fl_pend34", 64'(sb_pending), 64'h18);
    drive(1, 0, 0, 8, 1, 0, 0, 1, 0);
    check("fl_issue", 64'(issue), 64'd0);
    check("fl_stall", 64'(stall), 64'd0);
    tick();
    check("fl_keep", 64'(sb_pending), 64'h18);
    drive(1, 0, 0, 9, 1, 0, 0, 0, 0);
    check("dr_stall0", 64'(stall), 64'd1);
    check("dr_issue0", 64'(issue), 64'd0);
    tick();
    drive(1, 0, 0, 9, 1, 1, 3, 0, 0);
    check("dr_stall1", 64'(stall), 64'd1);
    tick();
    check("dr_pend4", 64'(sb_pending), 64'h10);
    drive(1, 0, 0, 9, 1, 1, 4, 0, 0);
    check("dr_stall2", 64'(stall), 64'd1);
    check("dr_issue2", 64'(issue), 64'd0);
    tick();
    check("dr_empty", 64'(sb_pending), 64'd0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    check("dr_run_issue", 64'(issue), 64'd1);
    check("dr_run_stall", 64'(stall), 64'd0);
    tick();
    check("dr_cnt", 64'(stall_cnt), 64'd5);

    // Saturation of the 4-bit stall counter
    drive(1, 0, 0, 10, 1, 0, 0, 0, 0);
    tick();
    drive(1, 10, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) tick();
    check("sat_cnt", 64'(stall_cnt), 64'd15);
    tick();
    check("sat_hold", 64'(stall_cnt), 64'd15);
    check("sat_stall", 64'(stall), 64'd1);
    drive(0, 0, 0, 0, 0, 1, 10, 0, 0);
    tick();

    // Error flag, then reset in DRAIN
    drive(0, 0, 0, 0, 0, 1, 9, 0, 0);
    tick();
    check("err_set", 64'(sb_err), 64'd1);
    drive(1, 0, 0, 11, 1, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    check("rd_drain_stall", 64'(stall), 64'd1);
    drive(1, 0, 0, 12, 1, 1, 11, 1, 1);
    check("rd_rst_issue", 64'(issue), 64'd0);
    check("rd_rst_stall", 64'(stall), 64'd0);
    tick();
    check("rd_pending", 64'(sb_pending), 64'd0);
    check("rd_cnt",     64'(stall_cnt),  64'd0);
    check("rd_err",     64'(sb_err),     64'd0);
    drive(1, 11, 0, 0, 0, 0, 0, 0, 0);
    check("rd_run_issue", 64'(issue), 64'd1);
    check("rd_run_stall", 64'(stall), 64'd0);
    tick();

    // Reset mid-STALL
    drive(1, 0, 0, 13, 1, 0, 0, 0, 0);
    tick();
    drive(1, 13, 0, 0, 0, 0, 0, 0, 0);
    check("rs_stall", 64'(stall), 64'd1);
    tick();
    drive(1, 13, 0, 0, 0, 0, 0, 0, 1);
    check("rs_rst_stall", 64'(stall), 64'd0);
    tick();
    drive(1, 13, 0, 0, 0, 0, 0, 0, 0);
    check("rs_run_issue", 64'(issue), 64'd1);
    tick();

    // Mixed traffic on a few registers, checked by the model each cycle
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            int'($urandom_range(0, 3)), ($urandom_range(0, 15) == 0), ($urandom_range(0, 63) == 0));
      tick();
    end

    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
